// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) types, bit-position map and coding helpers.
// Used by the decoder (HAMMING_DEC_STATS_EN adds its optional error counter) and the encoder.
package hamming_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned SYN_W  = 3;

    typedef logic [7:1]        codeword_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SYN_W-1:0]  syndrome_t;

    // Codeword positions are 1-based so a syndrome value names the bad position directly.
    localparam int unsigned P1_POS = 1;
    localparam int unsigned P2_POS = 2;
    localparam int unsigned D0_POS = 3;
    localparam int unsigned P4_POS = 4;
    localparam int unsigned D1_POS = 5;
    localparam int unsigned D2_POS = 6;
    localparam int unsigned D3_POS = 7;

    // Stage-1 payload: raw codeword plus its syndrome.
    typedef struct packed {
        codeword_t code;
        syndrome_t syndrome;
    } s1_word_t;

    // Stage-2 payload: what the output ports present.
    typedef struct packed {
        data_t     data;
        syndrome_t syndrome;
        logic      corrected;
    } dec_result_t;

    function automatic syndrome_t calc_syndrome(input codeword_t c);
        logic s1;
        logic s2;
        logic s4;
        s1 = c[P1_POS] ^ c[D0_POS] ^ c[D1_POS] ^ c[D3_POS];
        s2 = c[P2_POS] ^ c[D0_POS] ^ c[D2_POS] ^ c[D3_POS];
        s4 = c[P4_POS] ^ c[D1_POS] ^ c[D2_POS] ^ c[D3_POS];
        return {s4, s2, s1};
    endfunction

    // Flip the bit named by the syndrome; position p lives at LSB offset p-1.
    function automatic codeword_t correct_code(input codeword_t c, input syndrome_t syn);
        codeword_t fixed;
        fixed = c;
        if (syn != '0) begin
            fixed = c ^ (codeword_t'(1) << (syn - SYN_W'(1)));
        end
        return fixed;
    endfunction

    function automatic data_t extract_data(input codeword_t c);
        return {c[D3_POS], c[D2_POS], c[D1_POS], c[D0_POS]};
    endfunction

    function automatic codeword_t encode_data(input data_t d);
        codeword_t c;
        c         = '0;
        c[D0_POS] = d[0];
        c[D1_POS] = d[1];
        c[D2_POS] = d[2];
        c[D3_POS] = d[3];
        c[P1_POS] = d[0] ^ d[1] ^ d[3];
        c[P2_POS] = d[0] ^ d[2] ^ d[3];
        c[P4_POS] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

endpackage

// File: rtl/hamming_74_syndrome.sv
// Combinational Hamming(7,4) syndrome generator; reusable by decoder and checkers.
module hamming_74_syndrome
    import hamming_pkg::*;
(
    input  logic [7:1] code,
    output logic [2:0] syndrome_c
);

    assign syndrome_c = calc_syndrome(codeword_t'(code));

endmodule

// File: rtl/hamming_74_decoder.sv
// Two-stage valid/ready Hamming(7,4) decoder with single-error correction.
// Define HAMMING_DEC_STATS_EN to add clr_count/err_count and the saturating counter.
module hamming_74_decoder
    import hamming_pkg::*;
#(
    parameter int unsigned CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst,
`ifdef HAMMING_DEC_STATS_EN
    input  logic             clr_count,
    output logic [CNT_W-1:0] err_count,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:1]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_corrected
);

    s1_word_t    s1_d;
    s1_word_t    s1_q;
    logic        s1_valid_d;
    logic        s1_valid_q;
    dec_result_t s2_d;
    dec_result_t s2_q;
    logic        s2_valid_d;
    logic        s2_valid_q;

    syndrome_t   in_syn_c;
    codeword_t   fixed_c;
    logic        s1_adv_c;
    logic        s2_adv_c;

    hamming_74_syndrome u_syndrome (
        .code       (in_code),
        .syndrome_c (in_syn_c)
    );

    // Pipeline advance: an empty stage always accepts, so bubbles collapse.
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        s2_d       = s2_q;
        s2_valid_d = s2_valid_q;
        s2_adv_c   = !s2_valid_q || out_ready;
        s1_adv_c   = !s1_valid_q || s2_adv_c;
        fixed_c    = correct_code(s1_q.code, s1_q.syndrome);

        if (s1_adv_c) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.code     = in_code;
                s1_d.syndrome = in_syn_c;
            end
        end

        if (s2_adv_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.data      = extract_data(fixed_c);
                s2_d.syndrome  = s1_q.syndrome;
                s2_d.corrected = (s1_q.syndrome != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_q       <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_q       <= s2_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign in_ready      = s1_adv_c;
    assign out_valid     = s2_valid_q;
    assign out_data      = s2_q.data;
    assign out_syndrome  = s2_q.syndrome;
    assign out_corrected = s2_q.corrected;

`ifdef HAMMING_DEC_STATS_EN
    logic [CNT_W-1:0] err_count_d;
    logic [CNT_W-1:0] err_count_q;

    // Count corrected words as they leave; saturate, and let clear take priority.
    always_comb begin
        err_count_d = err_count_q;
        if (clr_count) begin
            err_count_d = '0;
        end else if (s2_valid_q && out_ready && s2_q.corrected && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule
